antilog2_unit: RTL and testbench

- Converts log-domain values back to linear: out = 2^(±L).
- Input is the same format the log2 converter produces: 32-bit magnitude, 5 integer bits and 27 fraction bits (bits [4:-27]), plus a separate sign bit.
- Sits downstream of the ncc datapath. It turns log-domain products and quotients into linear fixed-point scores for thresholding and the accumulator.
- Iterative, one fraction bit per cycle, with valid/ready handshakes on both sides.

---
 rtl/antilog2_unit.sv | 218 +++++++++++++++++++++
 tb/tb_antilog2_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/antilog2_unit.sv
// antilog2_unit: converts a log-domain value back to linear, out = 2^(+/-L).
//
// The fraction of L is consumed MSB first, one bit per cycle, by multiplying
// a Q2.30 accumulator by 2^(+/-2^-i) for every set fraction bit i. The
// integer part of L is then applied as a single barrel shift.
//
// Parameters:
//   FRAC_ITERS  fraction bits processed, 1..27 (lower bits are ignored)
//   OUT_W       output width
//   OUT_FRAC    output fraction bits (OUT_FRAC < OUT_W, OUT_FRAC <= 30)
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active low
//   in_valid   input word valid
//   in_ready   unit idle and able to accept an input
//   in_log     |L| in Q5.27
//   in_sign    1: result is 2^-|L|
//   in_zero    1: operand is linear zero, result forced to 0
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts the result
//   out_data   unsigned result, Q(OUT_W-OUT_FRAC).OUT_FRAC
//   out_sat    result saturated to all-ones
//
// Build option:
//   ANTILOG2_ROUND_EN  when defined, the final shift rounds to nearest
//                      (ties up) and saturates on carry out of OUT_W;
//                      otherwise it truncates toward zero.
module antilog2_unit #(
  parameter int FRAC_ITERS = 16,
  parameter int OUT_W      = 32,
  parameter int OUT_FRAC   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_log,
  input  logic             in_sign,
  input  logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);

  localparam int S       = 30 - OUT_FRAC;  // Q2.30 -> output fraction alignment
  localparam int INT_LIM = OUT_W - OUT_FRAC;
  localparam int WIDE    = OUT_W + 64;

  // Integer square root, used only at elaboration to build the ROMs.
  function automatic logic [63:0] isqrt128(input logic [127:0] v);
    logic [63:0]  r;
    logic [127:0] t;
    r = '0;
    for (int b = 63; b >= 0; b--) begin
      t = {64'd0, (r | (64'd1 << b))};
      if (t * t <= v) r = r | (64'd1 << b);
    end
    return r;
  endfunction

  // 2^(+/-2^-i) in Q2.30, truncated. Square roots are taken in Q.60 so the
  // repeated-root error stays far below the final Q2.30 LSB.
  function automatic logic [31:0] k_const(input int i, input logic neg);
    logic [127:0] k;
    k = {64'd0, isqrt128(128'd1 << 121)};
    for (int j = 2; j <= i; j++) k = {64'd0, isqrt128(k << 60)};
    if (neg) k = (128'd1 << 120) / k;
    return 32'(k >> 30);
  endfunction

  typedef enum logic [1:0] {IDLE, ITER, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      log_q, log_d;
  logic             sign_q, sign_d;
  logic             zero_q, zero_d;
  logic [31:0]      acc_q, acc_d;
  logic [4:0]       idx_q, idx_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             sat_q, sat_d;

  // Constant ROMs, indexed by i-1; entries past FRAC_ITERS are never selected.
  logic [31:0] kpos_rom [32];
  logic [31:0] kneg_rom [32];

  for (genvar gi = 0; gi < 32; gi++) begin : g_rom
    if (gi < FRAC_ITERS) begin : g_used
      localparam logic [31:0] KP = k_const(gi + 1, 1'b0);
      localparam logic [31:0] KN = k_const(gi + 1, 1'b1);
      assign kpos_rom[gi] = KP;
      assign kneg_rom[gi] = KN;
    end else begin : g_unused
      assign kpos_rom[gi] = '0;
      assign kneg_rom[gi] = '0;
    end
  end

  logic [4:0]  rom_idx;
  logic [4:0]  bit_pos;
  logic [31:0] k_sel;
  logic [63:0] prod;

  assign rom_idx = idx_q - 5'd1;
  assign bit_pos = 5'd27 - idx_q;
  assign k_sel   = sign_q ? kneg_rom[rom_idx] : kpos_rom[rom_idx];
  assign prod    = {32'd0, acc_q} * {32'd0, k_sel};

  // Final scaling by the integer part.
  logic [4:0]       n_int;
  logic [6:0]       neg_tot;
  logic [WIDE-1:0]  pos_res, neg_res;
  logic [OUT_W-1:0] shift_data;
  logic             shift_sat;

  assign n_int   = log_q[31:27];
  assign neg_tot = 7'(n_int) + 7'(S);

  always_comb begin
`ifdef ANTILOG2_ROUND_EN
    pos_res = ((WIDE'(acc_q) << n_int) + ((WIDE'(1) << S) >> 1)) >> S;
    neg_res = (WIDE'(acc_q) + ((WIDE'(1) << neg_tot) >> 1)) >> neg_tot;
`else
    pos_res = (WIDE'(acc_q) << n_int) >> S;
    neg_res = WIDE'(acc_q) >> neg_tot;
`endif
  end

  always_comb begin
    shift_data = '0;
    shift_sat  = 1'b0;
    if (zero_q) begin
      shift_data = '0;
    end else if (!sign_q) begin
      // Rounding can also carry past OUT_W, so the upper bits are checked.
      if (int'(n_int) >= INT_LIM || pos_res[WIDE-1:OUT_W] != '0) begin
        shift_data = '1;
        shift_sat  = 1'b1;
      end else begin
        shift_data = pos_res[OUT_W-1:0];
      end
    end else if (neg_tot < 7'd62) begin
      shift_data = OUT_W'(neg_res);
    end
  end

  always_comb begin
    state_d = state_q;
    log_d   = log_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    data_d  = data_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          log_d   = in_log;
          sign_d  = in_sign;
          zero_d  = in_zero;
          acc_d   = 32'h4000_0000;
          idx_d   = 5'd1;
          state_d = ITER;
        end
      end
      ITER: begin
        // A zero operand skips the multiplies; its single ITER slot fixes
        // the zero-case latency at two cycles.
        if (zero_q) begin
          state_d = SHIFT;
        end else begin
          if (log_q[bit_pos]) acc_d = 32'(prod >> 30);
          if (idx_q == 5'(FRAC_ITERS)) state_d = SHIFT;
          else                          idx_d   = idx_q + 5'd1;
        end
      end
      SHIFT: begin
        data_d  = shift_data;
        sat_d   = shift_sat;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      log_q   <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      acc_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      log_q   <= log_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_antilog2_unit.sv
// Directed bench for antilog2_unit at default parameters. Expected values
// are hand-computed from 2^(+/-L) in Q16.16.
module tb_antilog2_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_log;
  logic        in_sign;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sat;

  int n_tests = 0;
  int n_fail  = 0;

  antilog2_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_log    (in_log),
    .in_sign   (in_sign),
    .in_zero   (in_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp, input longint tol);
    longint diff;
    n_tests++;
    diff = (obs > exp) ? obs - exp : exp - obs;
    if (diff > tol) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // One full transaction: present, wait for the result, optionally stall the
  // output, optionally poke in_valid while busy, then complete the handshake.
  task automatic do_op(input string tag, input logic [31:0] lg, input logic sg, input logic zr,
                       input logic [31:0] exp_d, input int tol, input logic exp_s,
                       input int exp_lat, input int hold, input bit pulse);
    int cyc;
    bit rdy_seen;
    bit spurious;
    @(negedge clk);
    in_log = lg; in_sign = sg; in_zero = zr; in_valid = 1'b1;
    check({tag, "_rdy_idle"}, in_ready, 1, 0);
    @(posedge clk);  // acceptance edge E
    @(negedge clk);
    // Scramble inputs while busy; they must not matter.
    in_valid = 1'b0; in_log = 32'hDEAD_BEEF; in_sign = ~sg; in_zero = 1'b0;
    cyc = 0;
    rdy_seen = 1'b0;
    while (!out_valid && cyc < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      if (pulse && cyc == 3) begin
        in_valid = 1'b1; in_log = 32'h1000_0000; in_sign = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (in_ready) rdy_seen = 1'b1;
    $display("[TB] op %s log=0x%08h sign=%0d zero=%0d -> data=0x%08h sat=%0d after %0d edges",
             tag, lg, sg, zr, out_data, out_sat, cyc);
    check({tag, "_lat"}, cyc, exp_lat, 0);
    check({tag, "_data"}, out_data, exp_d, tol);
    check({tag, "_sat"}, out_sat, exp_s, 0);
    check({tag, "_rdy_busy"}, rdy_seen, 0, 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_v"}, out_valid, 1, 0);
      check({tag, "_hold_d"}, out_data, exp_d, tol);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_v_clr"}, out_valid, 0, 0);
    check({tag, "_rdy_back"}, in_ready, 1, 0);
    if (pulse) begin
      spurious = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk);
        @(negedge clk);
        if (out_valid || !in_ready) spurious = 1'b1;
      end
      check({tag, "_no_extra"}, spurious, 0, 0);
    end
  endtask

  initial begin
    bit spurious;
    rst = 1'b0; in_valid = 1'b0; in_log = '0; in_sign = 1'b0; in_zero = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", in_ready, 1, 0);
    check("rst_val", out_valid, 0, 0);
    check("rst_data", out_data, 0, 0);
    check("rst_sat", out_sat, 0, 0);
    rst = 1'b1;

    //     tag          in_log        sg  zr  expected       tol sat lat hold pulse
    do_op("p3_0",     32'h1800_0000, 0, 0, 32'h0008_0000, 0, 0, 17, 10, 0);
    do_op("p1_5",     32'h0C00_0000, 0, 0, 32'h0002_D413, 2, 0, 17, 0, 0);
    do_op("n1_0",     32'h0800_0000, 1, 0, 32'h0000_8000, 0, 0, 17, 0, 1);
    do_op("n20_0",    32'hA000_0000, 1, 0, 32'h0000_0000, 0, 0, 17, 0, 0);
    do_op("p20_0",    32'hA000_0000, 0, 0, 32'hFFFF_FFFF, 0, 1, 17, 3, 0);
    do_op("zero",     32'h1800_0000, 0, 1, 32'h0000_0000, 0, 0, 2,  0, 0);
    do_op("p15_0",    32'h7800_0000, 0, 0, 32'h8000_0000, 0, 0, 17, 0, 0);
    do_op("p16_0",    32'h8000_0000, 0, 0, 32'hFFFF_FFFF, 0, 1, 17, 0, 0);
    do_op("p1_lowig", 32'h0800_07FF, 0, 0, 32'h0002_0000, 0, 0, 17, 0, 0);
    do_op("n0_5",     32'h0400_0000, 1, 0, 32'd46341,     2, 0, 17, 0, 0);
    do_op("p2_25",    32'h1200_0000, 0, 0, 32'd311743,    2, 0, 17, 0, 0);
    do_op("p0_0",     32'h0000_0000, 0, 0, 32'h0001_0000, 0, 0, 17, 0, 0);

    // Reset during the fifth ITER cycle.
    @(negedge clk);
    in_log = 32'h1800_0000; in_sign = 1'b0; in_zero = 1'b0; in_valid = 1'b1;
    @(posedge clk);  // edge E
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("mid_rst_rdy", in_ready, 1, 0);
    check("mid_rst_val", out_valid, 0, 0);
    spurious = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) spurious = 1'b1;
    end
    check("mid_rst_quiet", spurious, 0, 0);
    do_op("post_rst", 32'h1800_0000, 0, 0, 32'h0008_0000, 0, 0, 17, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
